sys_array_sequencer: RTL and testbench

Command initiator for `sys_array_wrapper`. On a rising edge of a user `go` request it drives the wrapper's `load_params` and `start_comp` strobes with fixed, parameterised widths and spacing. It then waits a fixed compute interval, because the wrapper has no done flag, and captures the wrapper's `hex_connect` word into a result register with a one-cycle `result_valid` strobe. It sits between the board-level button logic and `sys_array_wrapper`, and replaces the hand-timed strobes used in simulation.

---
 rtl/sys_array_sequencer.sv | 123 ++++++++++++
 tb/tb_sys_array_sequencer.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/sys_array_sequencer.sv
// Command initiator for sys_array_wrapper: on a go rising edge it issues the
// load_params/start_comp strobes, waits out the compute time and captures hex_in.
module sys_array_sequencer #(
    parameter int DATA_WIDTH   = 8,
    parameter int ARRAY_W      = 4,
    parameter int ARRAY_L      = 4,
    parameter int CLOCK_DIVIDE = 2,
    parameter int PULSE_LEN    = CLOCK_DIVIDE,
    parameter int LOAD_GAP     = 1,
    parameter int COMP_WAIT    = (2 * ARRAY_W + ARRAY_L + 2) * CLOCK_DIVIDE
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      go,
    input  logic [4*DATA_WIDTH-1:0]   hex_in,
    output logic                      load_params,
    output logic                      start_comp,
    output logic                      busy,
    output logic [4*DATA_WIDTH-1:0]   result,
    output logic                      result_valid
);

    localparam int MAX_PG   = (PULSE_LEN > LOAD_GAP) ? PULSE_LEN : LOAD_GAP;
    localparam int MAX_ALL  = (MAX_PG > COMP_WAIT) ? MAX_PG : COMP_WAIT;
    localparam int CW       = $clog2(MAX_ALL + 1);

    localparam logic [CW-1:0] CNT_PULSE = CW'(PULSE_LEN - 1);
    localparam logic [CW-1:0] CNT_GAP   = CW'(LOAD_GAP - 1);
    localparam logic [CW-1:0] CNT_WAIT  = CW'(COMP_WAIT - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO  = CW'(0);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        GAP     = 3'd2,
        START   = 3'd3,
        CWAIT   = 3'd4,
        CAPTURE = 3'd5
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            go_q;

    // Sequencer FSM; every output is set from the state being entered (Moore, registered).
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= IDLE;
            cnt          <= CNT_ZERO;
            go_q         <= 1'b1;
            load_params  <= 1'b0;
            start_comp   <= 1'b0;
            busy         <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
        end else begin
            go_q         <= go;
            result_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (go && !go_q) begin
                        state       <= LOAD;
                        cnt         <= CNT_PULSE;
                        load_params <= 1'b1;
                        busy        <= 1'b1;
                    end else begin
                        state       <= IDLE;
                    end
                end
                LOAD: begin
                    if (cnt == CNT_ZERO) begin
                        state       <= GAP;
                        cnt         <= CNT_GAP;
                        load_params <= 1'b0;
                    end else begin
                        cnt         <= cnt - CNT_ONE;
                    end
                end
                GAP: begin
                    if (cnt == CNT_ZERO) begin
                        state       <= START;
                        cnt         <= CNT_PULSE;
                        start_comp  <= 1'b1;
                    end else begin
                        cnt         <= cnt - CNT_ONE;
                    end
                end
                START: begin
                    if (cnt == CNT_ZERO) begin
                        state       <= CWAIT;
                        cnt         <= CNT_WAIT;
                        start_comp  <= 1'b0;
                    end else begin
                        cnt         <= cnt - CNT_ONE;
                    end
                end
                CWAIT: begin
                    // The wrapper has no done flag, so the result is taken purely on time.
                    if (cnt == CNT_ZERO) begin
                        state        <= CAPTURE;
                        result       <= hex_in;
                        result_valid <= 1'b1;
                    end else begin
                        cnt          <= cnt - CNT_ONE;
                    end
                end
                CAPTURE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state       <= IDLE;
                    cnt         <= CNT_ZERO;
                    load_params <= 1'b0;
                    start_comp  <= 1'b0;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sys_array_sequencer.sv
// Directed bench for sys_array_sequencer: per-cycle output traces are packed
// into bit masks (bit c = cycle k+c) and compared against hand-computed masks.
module tb_sys_array_sequencer;

    logic        clk;
    logic        reset_n;
    logic        go;
    logic [31:0] hex_in;
    logic        load_params, start_comp, busy, result_valid;
    logic [31:0] result;
    logic        ld_b, st_b, bz_b, rv_b;
    logic [31:0] res_b;

    int n_cmp = 0;
    int n_err = 0;

    sys_array_sequencer dut (
        .clk(clk), .reset_n(reset_n), .go(go), .hex_in(hex_in),
        .load_params(load_params), .start_comp(start_comp), .busy(busy),
        .result(result), .result_valid(result_valid)
    );

    sys_array_sequencer #(.PULSE_LEN(1), .LOAD_GAP(3), .COMP_WAIT(5)) dut_b (
        .clk(clk), .reset_n(reset_n), .go(go), .hex_in(hex_in),
        .load_params(ld_b), .start_comp(st_b), .busy(bz_b),
        .result(res_b), .result_valid(rv_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Records cycles k+1..k+n; go is go_level except a one-cycle pulse at go_at,
    // hex_in switches to hex_new during cycle hex_at.
    task automatic window(input int n, input int go_at, input logic go_level,
                          input int hex_at, input logic [31:0] hex_new,
                          output logic [63:0] ld, output logic [63:0] st,
                          output logic [63:0] bz, output logic [63:0] rv,
                          output logic [63:0] ldb, output logic [63:0] stb,
                          output logic [63:0] bzb, output logic [63:0] rvb);
        ld = '0; st = '0; bz = '0; rv = '0;
        ldb = '0; stb = '0; bzb = '0; rvb = '0;
        for (int c = 1; c <= n; c++) begin
            ld[c] = load_params; st[c] = start_comp; bz[c] = busy; rv[c] = result_valid;
            ldb[c] = ld_b; stb[c] = st_b; bzb[c] = bz_b; rvb[c] = rv_b;
            go = (c == go_at) ? 1'b1 : go_level;
            if (c == hex_at) hex_in = hex_new;
            tick();
        end
    endtask

    logic [63:0] m_ld, m_st, m_bz, m_rv, m_ldb, m_stb, m_bzb, m_rvb;
    logic        any_strobe;

    localparam logic [63:0] EXP_LD = 64'h0000_0000_0000_0006;
    localparam logic [63:0] EXP_ST = 64'h0000_0000_0000_0030;
    localparam logic [63:0] EXP_BZ = 64'h0000_0007_FFFF_FFFE;
    localparam logic [63:0] EXP_RV = 64'h0000_0004_0000_0000;

    initial begin
        reset_n = 1'b0; go = 1'b0; hex_in = 32'hC0F9A4B0;
        repeat (4) tick();
        check_eq("rst_load",   {63'd0, load_params},  64'd0);
        check_eq("rst_start",  {63'd0, start_comp},   64'd0);
        check_eq("rst_busy",   {63'd0, busy},         64'd0);
        check_eq("rst_valid",  {63'd0, result_valid}, 64'd0);
        check_eq("rst_result", {32'd0, result},       64'd0);
        reset_n = 1'b1;
        tick();

        // Default run, with the swept-parameter instance running alongside.
        go = 1'b1; tick();
        window(40, 0, 1'b0, 0, 32'h0, m_ld, m_st, m_bz, m_rv, m_ldb, m_stb, m_bzb, m_rvb);
        check_eq("def_load",   m_ld, EXP_LD);
        check_eq("def_start",  m_st, EXP_ST);
        check_eq("def_busy",   m_bz, EXP_BZ);
        check_eq("def_valid",  m_rv, EXP_RV);
        check_eq("def_result", {32'd0, result}, 64'h0000_0000_C0F9_A4B0);
        check_eq("def_overlap", m_ld & m_st, 64'd0);
        check_eq("swp_load",   m_ldb, 64'h0000_0000_0000_0002);
        check_eq("swp_start",  m_stb, 64'h0000_0000_0000_0020);
        check_eq("swp_busy",   m_bzb, 64'h0000_0000_0000_0FFE);
        check_eq("swp_valid",  m_rvb, 64'h0000_0000_0000_0800);
        check_eq("swp_result", {32'd0, res_b}, 64'h0000_0000_C0F9_A4B0);

        // Capture instant: a change during the capture cycle is too late.
        hex_in = 32'h11111111;
        go = 1'b1; tick();
        window(36, 0, 1'b0, 34, 32'h22222222, m_ld, m_st, m_bz, m_rv, m_ldb, m_stb, m_bzb, m_rvb);
        check_eq("cap_late", {32'd0, result}, 64'h0000_0000_1111_1111);
        hex_in = 32'h11111111;
        go = 1'b1; tick();
        window(36, 0, 1'b0, 33, 32'h22222222, m_ld, m_st, m_bz, m_rv, m_ldb, m_stb, m_bzb, m_rvb);
        check_eq("cap_early", {32'd0, result}, 64'h0000_0000_2222_2222);

        // Ignored requests mid-run and in the CAPTURE cycle.
        go = 1'b1; tick();
        go = 1'b0;
        for (int c = 1; c <= 50; c++) begin
            m_ld[c] = load_params; m_bz[c] = busy;
            go = (c == 10 || c == 34) ? 1'b1 : 1'b0;
            tick();
        end
        check_eq("ign_load", m_ld & 64'h0007_FFFF_FFFF_FFFE, EXP_LD);
        check_eq("ign_busy", m_bz & 64'h0007_FFFF_FFFF_FFFE, EXP_BZ);
        go = 1'b1; tick();
        check_eq("fresh_load", {63'd0, load_params}, 64'd1);
        go = 1'b0;
        repeat (40) tick();

        // Earliest accepted follow-on edge, sampled at k+35.
        go = 1'b1; tick();
        window(40, 35, 1'b0, 0, 32'h0, m_ld, m_st, m_bz, m_rv, m_ldb, m_stb, m_bzb, m_rvb);
        check_eq("b2b_load", m_ld, 64'h0000_0030_0000_0006);
        check_eq("b2b_busy", m_bz, 64'h0000_01F7_FFFF_FFFE);
        repeat (40) tick();

        // go held high through reset release must not start a run.
        reset_n = 1'b0; go = 1'b1;
        repeat (3) tick();
        reset_n = 1'b1;
        any_strobe = 1'b0;
        for (int c = 0; c < 60; c++) begin
            any_strobe = any_strobe | load_params | start_comp | busy | result_valid;
            tick();
        end
        check_eq("held_quiet", {63'd0, any_strobe}, 64'd0);
        go = 1'b0; tick();
        go = 1'b1; tick();
        window(50, 0, 1'b1, 0, 32'h0, m_ld, m_st, m_bz, m_rv, m_ldb, m_stb, m_bzb, m_rvb);
        check_eq("held_once_load", m_ld, EXP_LD);
        check_eq("held_once_valid", m_rv, EXP_RV);
        go = 1'b0;
        repeat (5) tick();

        // Reset mid-run while start_comp is high.
        hex_in = 32'hA5A5_5A5A;
        go = 1'b1; tick();
        go = 1'b0;
        repeat (4) tick();
        check_eq("mid_start_hi", {63'd0, start_comp}, 64'd1);
        reset_n = 1'b0; tick();
        check_eq("mid_start",  {63'd0, start_comp},   64'd0);
        check_eq("mid_load",   {63'd0, load_params},  64'd0);
        check_eq("mid_busy",   {63'd0, busy},         64'd0);
        check_eq("mid_valid",  {63'd0, result_valid}, 64'd0);
        check_eq("mid_result", {32'd0, result},       64'd0);
        reset_n = 1'b1; tick();
        go = 1'b1; tick();
        window(40, 0, 1'b0, 0, 32'h0, m_ld, m_st, m_bz, m_rv, m_ldb, m_stb, m_bzb, m_rvb);
        check_eq("post_load",   m_ld, EXP_LD);
        check_eq("post_start",  m_st, EXP_ST);
        check_eq("post_valid",  m_rv, EXP_RV);
        check_eq("post_result", {32'd0, result}, 64'h0000_0000_A5A5_5A5A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
